// File: rtl/dict_pkg.sv
// Shared definitions for the dictionary write path: geometry of one
// fifo_dict entry, arbiter state encoding and requester indices.
package dict_pkg;

    localparam int DICT_DATA_WIDTH      = 32;
    localparam int DICT_WORDS_PER_ENTRY = 16;

    typedef enum logic {
        IDLE,
        BURST
    } dict_arb_state_t;

    localparam logic REQ_COMP   = 1'b0;
    localparam logic REQ_DECOMP = 1'b1;

endpackage

// File: rtl/dict_write_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright; when both
// ask, the one that did not hold the most recent grant wins.
module rr_arb2
    import dict_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx
);

    // Pick the winner from the request pair and the previous owner
    always_comb begin
        gnt_idx = REQ_COMP;
        case (req)
            2'b01:   gnt_idx = REQ_COMP;
            2'b10:   gnt_idx = REQ_DECOMP;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = REQ_COMP;
        endcase
    end

endmodule

// File: rtl/dict_write_arbiter.sv
// Shares the fifo_dict write port between the compressor and the
// decompressor/rebuild path. A grant lasts for one whole entry so the two
// streams never interleave words inside a dictionary line.
module dict_write_arbiter
    import dict_pkg::*;
#(
    parameter int  DATA_WIDTH      = DICT_DATA_WIDTH,
    parameter int  WORDS_PER_ENTRY = DICT_WORDS_PER_ENTRY,
    parameter int  LCNT_W          = 16,
    localparam int CNT_W           = $clog2(WORDS_PER_ENTRY)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    output logic [1:0]            req_ready,
    input  logic                  abort,
    output logic                  dict_wr,
    output logic [DATA_WIDTH-1:0] dict_w_data,
    output logic                  busy,
    output logic                  owner,
    output logic [CNT_W-1:0]      word_idx,
    output logic                  line_done,
    output logic [LCNT_W-1:0]     lines_written
);

    dict_arb_state_t       state, state_n;
    logic                  owner_n;
    logic [CNT_W-1:0]      idx_n;
    logic [LCNT_W-1:0]     lines_n;
    logic                  line_done_n;
    logic [DATA_WIDTH-1:0] last_data, last_data_n;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  gnt_idx;
    logic                  last_word;

    rr_arb2 u_rr_arb2 (
        .req     (req_valid),
        .last    (owner),
        .gnt_idx (gnt_idx)
    );

    assign owner_data  = (owner == REQ_DECOMP) ? req_data1 : req_data0;
    assign last_word   = (word_idx == CNT_W'(WORDS_PER_ENTRY - 1));
    assign busy        = (state == BURST);
    // Write data follows the owner while writing, otherwise holds the last word
    assign dict_w_data = dict_wr ? owner_data : last_data;

    // Next-state, grant bookkeeping and per-cycle handshake outputs
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        idx_n       = word_idx;
        lines_n     = lines_written;
        line_done_n = 1'b0;
        last_data_n = last_data;
        req_ready   = 2'b00;
        dict_wr     = 1'b0;
        case (state)
            IDLE: begin
                // One-cycle arbitration bubble: grant only, no transfer
                if (|req_valid) begin
                    owner_n = gnt_idx;
                    state_n = BURST;
                end
            end
            BURST: begin
                if (abort) begin
                    // Abort beats any coincident transfer, even the final word
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    req_ready[owner] = 1'b1;
                    if (req_valid[owner]) begin
                        dict_wr     = 1'b1;
                        last_data_n = owner_data;
                        if (last_word) begin
                            state_n     = IDLE;
                            idx_n       = '0;
                            line_done_n = 1'b1;
                            lines_n     = lines_written + LCNT_W'(1);
                        end else begin
                            idx_n = word_idx + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and bookkeeping registers; owner resets to 1 so requester 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= REQ_DECOMP;
            word_idx      <= '0;
            lines_written <= '0;
            line_done     <= 1'b0;
            last_data     <= '0;
        end else begin
            state         <= state_n;
            owner         <= owner_n;
            word_idx      <= idx_n;
            lines_written <= lines_n;
            line_done     <= line_done_n;
            last_data     <= last_data_n;
        end
    end

endmodule

// File: doc/dict_write_arbiter.md
Name: dict_write_arbiter

Overview:
Sequences writes into the single-entry dictionary (fifo_dict, 16 x 32-bit words per 64B entry) and shares its write port between two requesters: requester 0 is the compressor, requester 1 is the decompressor/rebuild path. Arbitration happens at line granularity. A granted requester owns the dictionary write port until it has written a complete 16-word entry. This prevents two streams from interleaving words in one entry. The block sits between the requesters' valid/ready streams and fifo_dict's wr/w_data inputs.

Parameters:
DATA_WIDTH, 32, width of one dictionary word
WORDS_PER_ENTRY, 16, words per dictionary entry (power of two, >=2)
CNT_W, $clog2(WORDS_PER_ENTRY), word-index width (derived, localparam)
LCNT_W, 16, width of the completed-line counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-requester word valid
req_data0  in  DATA_WIDTH  requester 0 word
req_data1  in  DATA_WIDTH  requester 1 word
req_ready  out  2  per-requester ready; at most one bit set
abort  in  1  cancel the current partial line
dict_wr  out  1  write strobe to fifo_dict
dict_w_data  out  DATA_WIDTH  write data to fifo_dict
busy  out  1  a line burst is in progress
owner  out  1  current or most recent grant holder
word_idx  out  CNT_W  next word slot in the current line
line_done  out  1  one-cycle pulse after a line completes
lines_written  out  LCNT_W  count of completed lines, wraps

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, owner=1 (so requester 0 wins first), word_idx=0, lines_written=0.
  - line_done=0, busy=0, req_ready=0, dict_wr=0, dict_w_data=0.
- FSM states: IDLE, BURST.
- IDLE:
  - req_ready=0, dict_wr=0.
  - If any req_valid bit is set, register a grant and move to BURST on the next edge.
  - One valid: that requester is granted.
  - Both valid: round-robin, the requester != owner is granted.
  - Cost: a one-cycle arbitration bubble per line; no word transfers in IDLE.
- BURST:
  - busy=1.
  - req_ready[owner]=1 and req_ready[~owner]=0, combinationally from state.
  - Transfer when req_valid[owner] & req_ready[owner].
  - dict_wr = transfer (combinational, same cycle).
  - dict_w_data = owner's data, muxed combinationally; held at the last written value when there is no transfer.
  - On each transfer, word_idx increments.
  - A gap in req_valid stalls the burst; the grant is held indefinitely.
- Line completion:
  - A transfer with word_idx==WORDS_PER_ENTRY-1 ends the line.
  - Next edge: state=IDLE, word_idx=0, line_done=1 for one cycle, lines_written+1 (wraps at 2^LCNT_W).
  - owner keeps its value, which makes it the "last owner" for round-robin.
- Throughput: 16 words in 16 cycles plus 1 arbitration cycle per line.
- abort in BURST:
  - Next edge: state=IDLE, word_idx=0, no line_done, lines_written unchanged.
  - A coincident transfer is suppressed: dict_wr=0 and req_ready forced to 0 in that cycle.
  - Words already written remain in fifo_dict; the owner is responsible for re-sending a full line.
- abort in IDLE: ignored.
- abort on the 16th-word cycle: abort wins; the line is not counted.
- fifo_dict wrap-around (the 17th word overwrites slot 0) is never reached mid-line, because a grant spans exactly WORDS_PER_ENTRY transfers.
- Reset mid-burst: immediate return to reset values; the partial line is lost.

Decomposition:
- Package dict_pkg:
  - DATA_WIDTH and WORDS_PER_ENTRY defaults, shared with fifo_dict.
  - typedef enum logic {IDLE, BURST} dict_arb_state_t.
  - Requester index constants REQ_COMP=0 and REQ_DECOMP=1.
- One natural sub-module: rr_arb2 (2-way round-robin picker: inputs req[1:0] and last; output gnt_idx). Everything else stays in the top.

Test Plan:
- Single requester: req_valid=01, data 0..15 back-to-back.
  - Expected: IDLE bubble 1 cycle, then dict_wr high for 16 cycles with data 0x0..0xF.
  - line_done pulses once; lines_written=1; owner=0.
- Both requesters continuously valid (r0 data 0x00.., r1 data 0x100..).
  - Lines alternate r0, r1, r0.
  - No interleaving within a line; req_ready is never 11.
  - lines_written=3 after 51 cycles.
- Stall: requester 0 drops valid after word 5 for 4 cycles while requester 1 is valid.
  - Grant is held; word_idx stays 6; no r1 words are written.
  - The line completes with 16 r0 words.
- Abort after 7 words: word_idx goes to 0 next edge; no line_done; lines_written unchanged.
  - Requester 1 (pending) is granted next.
- Abort coincident with the 16th transfer: dict_wr=0 that cycle, no line_done, count unchanged.
- Asynchronous reset mid-burst (word 9): all outputs take reset values immediately, without waiting for a clock edge.
  - After reset is released, requester 0 is granted first.
